fetch_unit: RTL

Instruction fetch stage of the RISC-V core, directly upstream of the decode/control path. Holds the PC, issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers up to two instructions. Delivers instruction, PC and the opcode field (`inst[6:0]`, the control unit's `part_of_inst`) to decode over a valid/ready handshake. Supports redirect from branch/jump resolution and a sticky halt on ECALL.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage. Holds the PC, issues word
// requests to instruction memory, tracks in-flight responses and buffers up
// to two {instruction, pc} pairs for decode. Supports redirects from branch
// resolution and a sticky halt on ECALL.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic        halted
);

  localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  out_cnt;
  logic [1:0]  drop_cnt;
  logic [1:0]  occ;

  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic        buf_rd;
  logic        buf_wr;

  logic [31:0] pend_pc [2];
  logic        pend_rd;
  logic        pend_wr;

  logic        running;
  logic        pop;
  logic        req_fire;
  logic        resp_fire;
  logic        redirect_take;
  logic        keep;
  logic        flush;
  logic [2:0]  credit_used;

  // A slot being popped this cycle counts as free, so single-cycle memory
  // sustains one instruction per cycle; the buffer still can never overflow.
  assign running       = (state == RUN);
  assign id_valid      = running && (occ != 2'd0);
  assign pop           = id_valid && id_ready;
  assign credit_used   = {1'b0, out_cnt} + {1'b0, occ} - {2'b00, pop};
  assign imem_req_valid = reset && running && (credit_used < CREDITS)
                          && !redirect_valid && !halt;
  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are protocol violations and ignored.
  assign resp_fire     = imem_resp_valid && (out_cnt != 2'd0);
  assign redirect_take = running && redirect_valid && !halt;
  assign flush         = !running || halt || redirect_take;
  assign keep          = resp_fire && (drop_cnt == 2'd0) && !flush;

  assign id_inst   = buf_inst[buf_rd];
  assign id_pc     = buf_pc[buf_rd];
  assign id_opcode = id_inst[6:0];
  assign halted    = (state == HALT);

  // Run/halt state machine; halt is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else if (halt) begin
      state <= HALT;
    end
  end

  // Fetch PC: jumps on redirect (word aligned), advances on accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_take) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Outstanding and to-be-dropped response counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt  <= 2'd0;
      drop_cnt <= 2'd0;
    end else begin
      out_cnt <= out_cnt + {1'b0, req_fire} - {1'b0, resp_fire};
      if (redirect_take) begin
        drop_cnt <= out_cnt - {1'b0, resp_fire};
      end else if (resp_fire && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  // Pending-address FIFO: PC of each accepted request, popped per response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        pend_pc[i] <= '0;
      end
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      if (req_fire) begin
        pend_pc[pend_wr] <= fetch_pc;
        pend_wr          <= ~pend_wr;
      end
      if (resp_fire) begin
        pend_rd <= ~pend_rd;
      end
    end
  end

  // Instruction buffer toward decode; flushed on redirect and halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
      buf_rd <= 1'b0;
      buf_wr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      buf_rd <= 1'b0;
      buf_wr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (keep) begin
        buf_inst[buf_wr] <= imem_resp_data;
        buf_pc[buf_wr]   <= pend_pc[pend_rd];
        buf_wr           <= ~buf_wr;
      end
      if (pop) begin
        buf_rd <= ~buf_rd;
      end
      occ <= occ + {1'b0, keep} - {1'b0, pop};
    end
  end

endmodule
